// File: rtl/sync_event_pkg.sv
// Shared mode encodings and helpers for the synchronized event bank.
// Imported by sync_event_chan and sync_event_bank.
package sync_event_pkg;

    localparam int MODE_W     = 2;
    localparam int FILT_CNT_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } mode_e;

    function automatic logic edge_hit(input logic [MODE_W-1:0] mode,
                                      input logic rise,
                                      input logic fall);
        case (mode_e'(mode))
            MODE_RISE: return rise;
            MODE_FALL: return fall;
            MODE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_event_chan.sv
// One channel: synchronizer chain, optional glitch filter (SYNC_GLITCH_FILTER_EN),
// edge detect, saturating event counter with sticky flag and overflow.
module sync_event_chan
    import sync_event_pkg::*;
#(
    parameter int STAGES   = 2,
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              async_in,
    input  logic              ena,
    input  logic [MODE_W-1:0] mode,
    input  logic              clr,
    output logic              sync_out,
    output logic              pulse_out,
    output logic              flag,
    output logic              ovf,
    output logic [CNT_W-1:0]  cnt
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              level;
    logic              prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flag_q, flag_d;
    logic              ovf_q, ovf_d;
    logic              pulse;

`ifdef SYNC_GLITCH_FILTER_EN
    logic                  filt_q, filt_d;
    logic [FILT_CNT_W-1:0] stab_q, stab_d;

    // The filtered level follows the chain only once it has disagreed for FILT_LEN cycles.
    always_comb begin
        filt_d = filt_q;
        stab_d = '0;
        if (sync_q[STAGES-1] != filt_q) begin
            if (stab_q == FILT_CNT_W'(FILT_LEN - 1))
                filt_d = sync_q[STAGES-1];
            else
                stab_d = stab_q + FILT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else begin
            filt_q <= filt_d;
            stab_q <= stab_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[STAGES-1];
`endif

    assign pulse = ena & edge_hit(mode, level & ~prev_q, ~level & prev_q);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = level;
        cnt_d  = cnt_q;
        flag_d = flag_q;
        ovf_d  = ovf_q;
        if (clr) begin
            cnt_d  = '0;
            flag_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (pulse) begin
            flag_d = 1'b1;
            if (cnt_q == '1)
                ovf_d = 1'b1;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sync_out  = level;
    assign pulse_out = pulse;
    assign flag      = flag_q;
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/sync_event_bank.sv
// Bank of CHANNELS synchronized event counters with per-channel and global clear.
// Optional glitch filter selected by defining SYNC_GLITCH_FILTER_EN.
module sync_event_bank
    import sync_event_pkg::*;
#(
    parameter  int CHANNELS = 8,
    parameter  int STAGES   = 2,
    parameter  int CNT_W    = 8,
    parameter  int FILT_LEN = 3,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] async_in,
    input  logic                ena,
    input  logic [MODE_W-1:0]   mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                clr,
    input  logic                clr_all,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] flag,
    output logic [CHANNELS-1:0] ovf,
    output logic [CNT_W-1:0]    cnt_out
);

    logic [CHANNELS-1:0] chan_clr;
    logic [CNT_W-1:0]    cnt_arr [CHANNELS];

    // An out-of-range sel matches no channel, so clr and cnt_out see nothing.
    always_comb begin
        chan_clr = '0;
        cnt_out  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            chan_clr[i] = clr_all | (clr & (sel == SEL_W'(i)));
            if (sel == SEL_W'(i))
                cnt_out = cnt_arr[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        sync_event_chan #(
            .STAGES   (STAGES),
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .async_in  (async_in[g]),
            .ena       (ena),
            .mode      (mode),
            .clr       (chan_clr[g]),
            .sync_out  (sync_out[g]),
            .pulse_out (pulse_out[g]),
            .flag      (flag[g]),
            .ovf       (ovf[g]),
            .cnt       (cnt_arr[g])
        );
    end

endmodule

// File: tb/tb_sync_event_bank.sv
// Directed self-checking bench for sync_event_bank (8 channels, 4-bit counters).
// Filter-specific steps run only when SYNC_GLITCH_FILTER_EN is defined.
module tb_sync_event_bank;

    localparam int CH = 8;
    localparam int ST = 2;
    localparam int CW = 4;
    localparam int FL = 3;
`ifdef SYNC_GLITCH_FILTER_EN
    localparam int LAT = ST + FL;
`else
    localparam int LAT = ST;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] ain;
    logic          ena;
    logic [1:0]    mode;
    logic [2:0]    sel;
    logic          clr;
    logic          clr_all;
    logic [CH-1:0] sync_out, pulse_out, flag, ovf;
    logic [CW-1:0] cnt_out;

    int n_assert = 0;
    int n_fail   = 0;

    sync_event_bank #(
        .CHANNELS (CH),
        .STAGES   (ST),
        .CNT_W    (CW),
        .FILT_LEN (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (ain),
        .ena       (ena),
        .mode      (mode),
        .sel       (sel),
        .clr       (clr),
        .clr_all   (clr_all),
        .sync_out  (sync_out),
        .pulse_out (pulse_out),
        .flag      (flag),
        .ovf       (ovf),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ain = '0; ena = 1'b1; mode = 2'b00;
        sel = 3'd0; clr = 1'b0; clr_all = 1'b0;
        tick(); tick();
        chk("rst_sync", 32'(sync_out), 32'h0);
        chk("rst_pulse", 32'(pulse_out), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_cnt", 32'(cnt_out), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single rising edge on ch3
        sel = 3'd3;
        ain[3] = 1'b1;
        repeat (LAT - 1) tick();
        chk("ch3_sync_early", 32'(sync_out), 32'h0);
        tick();
        chk("ch3_sync", 32'(sync_out), 32'h08);
        chk("ch3_pulse", 32'(pulse_out), 32'h08);
        chk("ch3_cnt_before", 32'(cnt_out), 32'h0);
        tick();
        chk("ch3_pulse_gone", 32'(pulse_out), 32'h0);
        chk("ch3_cnt", 32'(cnt_out), 32'h1);
        chk("ch3_flag", 32'(flag), 32'h08);

        // clr on ch2 discards its event while ch5 still counts
        ain[2] = 1'b1; ain[5] = 1'b1;
        repeat (LAT) tick();
        chk("clr_pulse", 32'(pulse_out), 32'h24);
        clr = 1'b1; sel = 3'd2;
        tick();
        clr = 1'b0;
        chk("clr_ch2_cnt", 32'(cnt_out), 32'h0);
        chk("clr_flag", 32'(flag), 32'h28);
        sel = 3'd5; #1;
        chk("clr_ch5_cnt", 32'(cnt_out), 32'h1);

        // Falling mode on ch3 and ch5
        mode = 2'b01; ain[3] = 1'b0; ain[5] = 1'b0;
        repeat (LAT) tick();
        chk("fall_pulse", 32'(pulse_out), 32'h28);
        tick();
        sel = 3'd3; #1;
        chk("fall_ch3_cnt", 32'(cnt_out), 32'h2);
        sel = 3'd5; #1;
        chk("fall_ch5_cnt", 32'(cnt_out), 32'h2);

        // Both-edge mode
        mode = 2'b10; ain[3] = 1'b1; sel = 3'd3;
        repeat (LAT) tick();
        chk("both_pulse", 32'(pulse_out), 32'h08);
        tick();
        chk("both_cnt", 32'(cnt_out), 32'h3);

        // Mode none suppresses events
        mode = 2'b11; ain[3] = 1'b0;
        repeat (LAT) tick();
        chk("none_sync", 32'(sync_out), 32'h04);
        chk("none_pulse", 32'(pulse_out), 32'h0);
        tick();
        chk("none_cnt", 32'(cnt_out), 32'h3);

        // Mode switch acts in the same cycle
        ain[3] = 1'b1;
        repeat (LAT) tick();
        chk("modesw_before", 32'(pulse_out), 32'h0);
        mode = 2'b00; #1;
        chk("modesw_after", 32'(pulse_out), 32'h08);
        tick();
        chk("modesw_cnt", 32'(cnt_out), 32'h4);
        chk("modesw_flag", 32'(flag), 32'h28);

        // ena=0: sync tracks, no pulses, no counting
        mode = 2'b10; ena = 1'b0; sel = 3'd6;
        for (int k = 0; k < 4; k++) begin
            ain[6] = ~ain[6];
            repeat (LAT) tick();
            chk("ena0_sync", 32'(sync_out[6]), 32'(ain[6]));
            chk("ena0_pulse", 32'(pulse_out), 32'h0);
            tick();
        end
        ena = 1'b1; #1;
        chk("ena0_cnt", 32'(cnt_out), 32'h0);
        chk("ena0_flag", 32'(flag), 32'h28);

        // Saturation on ch0 with 4-bit counters
        mode = 2'b00; sel = 3'd0;
        for (int i = 1; i <= 17; i++) begin
            ain[0] = 1'b1;
            repeat (LAT) tick();
            ain[0] = 1'b0;
            repeat (LAT) tick();
            chk("sat_cnt", 32'(cnt_out), (i < 15) ? 32'(i) : 32'd15);
            chk("sat_ovf", 32'(ovf[0]), (i >= 16) ? 32'd1 : 32'd0);
        end
        chk("sat_flag", 32'(flag), 32'h29);

        // Global clear
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        chk("clrall_flag", 32'(flag), 32'h0);
        chk("clrall_ovf", 32'(ovf), 32'h0);
        chk("clrall_cnt0", 32'(cnt_out), 32'h0);
        sel = 3'd3; #1;
        chk("clrall_cnt3", 32'(cnt_out), 32'h0);

        // Reset mid-count on ch7, with ch2/ch3 held high through reset
        sel = 3'd7;
        for (int i = 0; i < 9; i++) begin
            ain[7] = 1'b1;
            repeat (LAT) tick();
            ain[7] = 1'b0;
            repeat (LAT) tick();
        end
        chk("pre_rst_cnt7", 32'(cnt_out), 32'h9);
        chk("pre_rst_sync", 32'(sync_out), 32'h0C);
        rst_n = 1'b0;
        tick();
        chk("midrst_sync", 32'(sync_out), 32'h0);
        chk("midrst_pulse", 32'(pulse_out), 32'h0);
        chk("midrst_flag", 32'(flag), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        chk("midrst_cnt", 32'(cnt_out), 32'h0);
        rst_n = 1'b1;
        repeat (LAT - 1) tick();
        chk("hold_sync_early", 32'(sync_out), 32'h0);
        tick();
        chk("hold_sync", 32'(sync_out), 32'h0C);
        chk("hold_pulse", 32'(pulse_out), 32'h0C);
        tick();
        chk("hold_pulse_gone", 32'(pulse_out), 32'h0);
        chk("hold_cnt7", 32'(cnt_out), 32'h0);
        sel = 3'd3; #1;
        chk("hold_cnt3", 32'(cnt_out), 32'h1);
        chk("hold_flag", 32'(flag), 32'h0C);

`ifdef SYNC_GLITCH_FILTER_EN
        begin
            int rises = 0;
            int falls = 0;
            logic prev_s;
            mode = 2'b10; sel = 3'd1;
            prev_s = sync_out[1];
            ain[1] = 1'b1;
            tick(); tick();
            ain[1] = 1'b0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (sync_out[1] && !prev_s) rises++;
                if (!sync_out[1] && prev_s) falls++;
                prev_s = sync_out[1];
            end
            chk("glitch_rises", 32'(rises), 32'd0);
            chk("glitch_cnt", 32'(cnt_out), 32'h0);
            ain[1] = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (sync_out[1] && !prev_s) rises++;
                if (!sync_out[1] && prev_s) falls++;
                prev_s = sync_out[1];
            end
            ain[1] = 1'b0;
            for (int k = 0; k < 15; k++) begin
                tick();
                if (sync_out[1] && !prev_s) rises++;
                if (!sync_out[1] && prev_s) falls++;
                prev_s = sync_out[1];
            end
            chk("filt_rises", 32'(rises), 32'd1);
            chk("filt_falls", 32'(falls), 32'd1);
            chk("filt_cnt", 32'(cnt_out), 32'h2);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
